term_ctrl: RTL and testbench

TERM_CTRL -- requirements
Module: term_ctrl

---
 rtl/term_ctrl.sv | 142 ++++++++++++++
 tb/tb_term_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/term_ctrl.sv
// rtl/term_ctrl.sv - text terminal controller: byte stream to index-RAM writes and scroll/clear blits
module term_ctrl #(
   parameter int COLS = 80,
   parameter int ROWS = 25
) (
   input  logic        clk100,
   input  logic        rst_n,
   input  logic        in_valid,
   input  logic [7:0]  in_data,
   output logic        in_ready,
   output logic        wr_en,
   output logic [10:0] wr_addr,
   output logic [7:0]  wr_data,
   output logic        blit_en,
   output logic [10:0] blit_start,
   output logic [10:0] blit_end,
   output logic [7:0]  blit_offset,
   input  logic        blit_complete,
   output logic [6:0]  cursor_col,
   output logic [4:0]  cursor_row,
   output logic        busy
);

   localparam logic [6:0]  LAST_COL     = 7'(COLS - 1);
   localparam logic [4:0]  LAST_ROW     = 5'(ROWS - 1);
   localparam logic [10:0] COLS_W       = 11'(COLS);
   localparam logic [10:0] SCREEN_CELLS = 11'(ROWS * COLS);
   localparam logic [10:0] LAST_LINE    = 11'((ROWS - 1) * COLS);
   localparam logic [7:0]  LINE_CELLS   = 8'(COLS);

   typedef enum logic [2:0] {
      IDLE,
      WRITE,
      SCROLL_REQ,
      SCROLL_WAIT,
      CLEAR_REQ,
      CLEAR_WAIT
   } state_t;

   state_t      state;
   logic [6:0]  col;
   logic [4:0]  row;
   logic        scroll_pend;   // printable byte wrapped off the bottom row
   logic [10:0] cell_addr;

   assign cell_addr  = 11'(row) * COLS_W + 11'(col);
   assign in_ready   = (state == IDLE);
   assign busy       = (state != IDLE);
   assign cursor_col = col;
   assign cursor_row = row;

   // Byte decode, cursor tracking and the scroll/clear blit sequencer
   always_ff @(posedge clk100 or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         col         <= '0;
         row         <= '0;
         scroll_pend <= 1'b0;
         wr_en       <= 1'b0;
         wr_addr     <= '0;
         wr_data     <= '0;
         blit_en     <= 1'b0;
         blit_start  <= '0;
         blit_end    <= '0;
         blit_offset <= '0;
      end else begin
         wr_en   <= 1'b0;
         blit_en <= 1'b0;
         case (state)
            IDLE: begin
               if (in_valid) begin
                  if (in_data >= 8'h20 && in_data <= 8'h7E) begin
                     wr_en       <= 1'b1;
                     wr_addr     <= cell_addr;
                     wr_data     <= in_data;
                     state       <= WRITE;
                     scroll_pend <= 1'b0;
                     if (col == LAST_COL) begin
                        col <= '0;
                        if (row < LAST_ROW) row <= row + 5'd1;
                        else                scroll_pend <= 1'b1;
                     end else begin
                        col <= col + 7'd1;
                     end
                  end else begin
                     case (in_data)
                        8'h0A: begin
                           if (row < LAST_ROW) begin
                              row <= row + 5'd1;
                           end else begin
                              state       <= SCROLL_REQ;
                              blit_en     <= 1'b1;
                              blit_start  <= '0;
                              blit_end    <= LAST_LINE;
                              blit_offset <= LINE_CELLS;
                           end
                        end
                        8'h0D: col <= '0;
                        8'h08: if (col != 7'd0) col <= col - 7'd1;
                        8'h0C: begin
                           col         <= '0;
                           row         <= '0;
                           state       <= CLEAR_REQ;
                           blit_en     <= 1'b1;
                           blit_start  <= '0;
                           blit_end    <= SCREEN_CELLS;
                           blit_offset <= '0;
                        end
                        default: ;
                     endcase
                  end
               end
            end
            WRITE: begin
               if (scroll_pend) begin
                  state       <= SCROLL_REQ;
                  blit_en     <= 1'b1;
                  blit_start  <= '0;
                  blit_end    <= LAST_LINE;
                  blit_offset <= LINE_CELLS;
               end else begin
                  state <= IDLE;
               end
            end
            SCROLL_REQ: state <= SCROLL_WAIT;
            SCROLL_WAIT: begin
               if (blit_complete) begin
                  state       <= CLEAR_REQ;
                  blit_en     <= 1'b1;
                  blit_start  <= LAST_LINE;
                  blit_end    <= SCREEN_CELLS;
                  blit_offset <= '0;
               end
            end
            CLEAR_REQ: state <= CLEAR_WAIT;
            CLEAR_WAIT: if (blit_complete) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_term_ctrl.sv
// tb/tb_term_ctrl.sv - randomized self-checking bench for term_ctrl against a cursor/screen model
module tb_term_ctrl;
   localparam int COLS = 80;
   localparam int ROWS = 25;

   logic        clk100 = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic [7:0]  in_data = 8'h00;
   logic        blit_complete = 1'b0;
   logic        in_ready, wr_en, blit_en, busy;
   logic [10:0] wr_addr, blit_start, blit_end;
   logic [7:0]  wr_data, blit_offset;
   logic [6:0]  cursor_col;
   logic [4:0]  cursor_row;

   term_ctrl #(.COLS(COLS), .ROWS(ROWS)) dut (
      .clk100(clk100), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .blit_en(blit_en), .blit_start(blit_start), .blit_end(blit_end),
      .blit_offset(blit_offset), .blit_complete(blit_complete),
      .cursor_col(cursor_col), .cursor_row(cursor_row), .busy(busy)
   );

   always #5 clk100 = ~clk100;

   int vectors = 0;
   int miscompares = 0;

   // reference model: cursor position plus the expected effects of one byte
   int m_col = 0, m_row = 0;
   int e_nw, e_waddr, e_nb, e_low;
   int e_bs[3], e_be[3], e_bo[3];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic add_blit(input int s, input int e, input int o);
      if (e_nb < 3) begin
         e_bs[e_nb] = s; e_be[e_nb] = e; e_bo[e_nb] = o;
      end
      e_nb++;
   endtask

   task automatic model_newline();
      if (m_row < ROWS - 1) m_row++;
      else begin
         add_blit(0, (ROWS - 1) * COLS, COLS);
         add_blit((ROWS - 1) * COLS, ROWS * COLS, 0);
         e_low = -1;
      end
   endtask

   task automatic model_byte(input logic [7:0] b);
      e_nw = 0; e_nb = 0; e_low = 0;
      if (b >= 8'h20 && b <= 8'h7E) begin
         e_nw = 1; e_waddr = m_row * COLS + m_col; e_low = 1;
         m_col++;
         if (m_col == COLS) begin m_col = 0; model_newline(); end
      end else if (b == 8'h0A) model_newline();
      else if (b == 8'h0D) m_col = 0;
      else if (b == 8'h08) begin if (m_col > 0) m_col--; end
      else if (b == 8'h0C) begin
         m_col = 0; m_row = 0; add_blit(0, ROWS * COLS, 0); e_low = -1;
      end
   endtask

   // drive one byte, answer blits with delayed completions, compare against the model
   task automatic send(input logic [7:0] b);
      int nw, waddr, wdata, nb, low, glitch, cd, guard;
      int bs[3], be[3], bo[3];
      model_byte(b);
      guard = 0;
      while (!in_ready && guard < 100) begin @(negedge clk100); guard++; end
      check("ready_before", in_ready, 1);
      in_valid = 1'b1; in_data = b;
      @(negedge clk100);
      in_valid = 1'b0;
      nw = 0; waddr = 0; wdata = 0; nb = 0; low = 0; glitch = 0; cd = 0; guard = 0;
      while (guard < 200) begin
         blit_complete = 1'b0;
         if (wr_en) begin
            if (nw == 0) begin waddr = wr_addr; wdata = wr_data; end
            nw++;
         end
         if (blit_en) begin
            if (nb < 3) begin bs[nb] = blit_start; be[nb] = blit_end; bo[nb] = blit_offset; end
            nb++;
            cd = $urandom_range(1, 4);
         end else if (cd > 0) begin
            if (nb <= 3) begin
               check("hold_start", blit_start, bs[nb-1]);
               check("hold_end", blit_end, be[nb-1]);
               check("hold_offset", blit_offset, bo[nb-1]);
            end
            cd--;
            if (cd == 0) blit_complete = 1'b1;
         end
         if (!in_ready) low++;
         else if (cd == 0 && !blit_complete) break;
         else glitch++;
         @(negedge clk100);
         guard++;
      end
      blit_complete = 1'b0;
      check("done_in_budget", guard < 200, 1);
      check("write_count", nw, e_nw);
      if (e_nw > 0 && nw > 0) begin
         check("wr_addr", waddr, e_waddr);
         check("wr_data", wdata, b);
      end
      check("blit_count", nb, e_nb);
      for (int i = 0; i < 3; i++) begin
         if (i < e_nb && i < nb) begin
            check("blit_start", bs[i], e_bs[i]);
            check("blit_end", be[i], e_be[i]);
            check("blit_offset", bo[i], e_bo[i]);
         end
      end
      if (e_low >= 0) check("ready_low_cycles", low, e_low);
      check("ready_glitch", glitch, 0);
      check("cursor_col", cursor_col, m_col);
      check("cursor_row", cursor_row, m_row);
      check("busy_idle", busy, 0);
   endtask

   task automatic goto_cell(input int c, input int r);
      send(8'h0C);
      for (int i = 0; i < r; i++) send(8'h0A);
      for (int i = 0; i < c; i++) send(8'h2E);
   endtask

   function automatic logic [7:0] random_byte();
      int r;
      logic [7:0] b;
      r = $urandom_range(0, 99);
      if (r < 60) b = 8'($urandom_range(32, 126));
      else if (r < 72) b = 8'h0A;
      else if (r < 80) b = 8'h0D;
      else if (r < 88) b = 8'h08;
      else if (r < 91) b = 8'h0C;
      else begin
         b = 8'($urandom_range(0, 255));
         while ((b >= 8'h20 && b <= 8'h7E) || b == 8'h0A || b == 8'h0D || b == 8'h08 || b == 8'h0C)
            b = 8'($urandom_range(0, 255));
      end
      return b;
   endfunction

   initial begin
      int stray;
      // reset state
      #12;
      check("rst_wr_en", wr_en, 0);
      check("rst_wr_addr", wr_addr, 0);
      check("rst_wr_data", wr_data, 0);
      check("rst_blit_en", blit_en, 0);
      check("rst_blit_start", blit_start, 0);
      check("rst_blit_end", blit_end, 0);
      check("rst_blit_offset", blit_offset, 0);
      check("rst_busy", busy, 0);
      check("rst_col", cursor_col, 0);
      check("rst_row", cursor_row, 0);
      @(negedge clk100);
      rst_n = 1'b1;
      @(negedge clk100);
      check("rel_in_ready", in_ready, 1);

      // first printable, then CR/LF mid-screen
      send(8'h41);
      goto_cell(10, 3);
      send(8'h0D);
      send(8'h0A);
      check("crlf_col", cursor_col, 0);
      check("crlf_row", cursor_row, 4);

      // line feed on the bottom row, then a full bottom line with auto-wrap
      goto_cell(0, ROWS - 1);
      send(8'h0A);
      for (int i = 0; i < COLS; i++) send(8'($urandom_range(32, 126)));
      check("wrap_col", cursor_col, 0);
      check("wrap_row", cursor_row, ROWS - 1);

      // form feed from (5,7)
      goto_cell(5, 7);
      send(8'h0C);

      // random traffic
      for (int i = 0; i < 300; i++) send(random_byte());

      // reset while waiting for the scroll blit
      goto_cell(0, ROWS - 1);
      @(negedge clk100);
      in_valid = 1'b1; in_data = 8'h0A;
      @(negedge clk100);
      in_valid = 1'b0;
      check("sw_blit_en", blit_en, 1);
      @(negedge clk100);
      check("sw_busy", busy, 1);
      #2 rst_n = 1'b0;
      #1;
      check("async_busy", busy, 0);
      check("async_row", cursor_row, 0);
      check("async_blit_end", blit_end, 0);
      @(negedge clk100);
      rst_n = 1'b1;
      m_col = 0; m_row = 0;
      blit_complete = 1'b1;
      @(negedge clk100);
      blit_complete = 1'b0;
      stray = 0;
      for (int i = 0; i < 6; i++) begin
         if (blit_en || busy) stray++;
         @(negedge clk100);
      end
      check("stray_complete", stray, 0);
      check("post_rst_ready", in_ready, 1);
      check("post_rst_col", cursor_col, 0);
      check("post_rst_row", cursor_row, 0);
      send(8'h5A);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
